// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the synchronous FIFO family.
// Read-mode encodings and the threshold legality check used by fifo_sync_param.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Legal ranges: almost_full in 1..depth, almost_empty in 0..depth-1.
  function automatic bit fifo_thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

  function automatic bit fifo_mode_ok(input int mode);
    return (mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: synchronous write, read port either registered or asynchronous.
// The registered read port clears on reset so the FIFO output starts at zero.
module fifo_ram_sdp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int ASYNC_READ = 0,
  parameter     TYPE       = "distributed"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  // Contents deliberately survive reset so the array maps onto plain RAM primitives.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  generate
    if (ASYNC_READ != 0) begin : g_async_rd
      logic w_unused_rd;
      assign w_unused_rd = reset ^ i_rd_en;
      assign o_rd_data   = r_mem[i_rd_addr];
    end else begin : g_sync_rd
      logic [DATA_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rd_data <= '0;
        end else if (i_rd_en) begin
          r_rd_data <= r_mem[i_rd_addr];
        end
      end
      assign o_rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with standard or first-word-fall-through read mode,
// visible fill level, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter     TYPE          = "distributed"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  output logic                  s_write_ready,
  input  logic                  s_read_req,
  output logic                  s_read_ready,
  output logic [DATA_WIDTH-1:0] s_read_data,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clear
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

  generate
    if (!fifo_thresh_ok(RAM_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("fifo_sync_param: AFULL_THRESH/AEMPTY_THRESH out of range for depth");
    end
    if (!fifo_mode_ok(FWFT)) begin : g_bad_mode
      $error("fifo_sync_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_fill_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_full   = (r_fill_count == LP_DEPTH);
  assign w_empty  = (r_fill_count == '0);
  // Masking with reset keeps the RAM from being written while the FIFO is held in reset.
  assign w_wr_acc = s_write_req & ~w_full & ~reset;
  assign w_rd_acc = s_read_req & ~w_empty & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill_count <= r_fill_count + 1'b1;
        2'b01:   r_fill_count <= r_fill_count - 1'b1;
        default: r_fill_count <= r_fill_count;
      endcase
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (s_write_req && w_full)       r_overflow <= 1'b1;
      else if (err_clear)              r_overflow <= 1'b0;
      if (s_read_req && w_empty)       r_underflow <= 1'b1;
      else if (err_clear)              r_underflow <= 1'b0;
    end
  end

  fifo_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ASYNC_READ (FWFT),
    .TYPE       (TYPE)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_write_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_out
      assign s_read_data = w_empty ? '0 : w_ram_q;
    end else begin : g_std_out
      assign s_read_data = w_ram_q;
    end
  endgenerate

  assign s_write_ready = ~w_full;
  assign s_read_ready  = ~w_empty;
  assign fill_count    = r_fill_count;
  assign almost_full   = (r_fill_count >= LP_AFULL);
  assign almost_empty  = (r_fill_count <= LP_AEMPTY);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench driving a standard-mode and an FWFT-mode FIFO (depth 4) with identical stimulus.
// Expected values are hand-derived from the depth-4, afull=3, aempty=1 configuration.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wd = 8'h00;

  logic       wrdy [2];
  logic       rrdy [2];
  logic [7:0] rdat [2];
  logic [2:0] cnt  [2];
  logic       af   [2];
  logic       ae   [2];
  logic       ov   [2];
  logic       un   [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_std (
    .clk(clk), .reset(reset), .s_write_req(wr), .s_write_data(wd), .s_write_ready(wrdy[0]),
    .s_read_req(rd), .s_read_ready(rrdy[0]), .s_read_data(rdat[0]), .fill_count(cnt[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]), .underflow(un[0]), .err_clear(clr));

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .reset(reset), .s_write_req(wr), .s_write_data(wd), .s_write_ready(wrdy[1]),
    .s_read_req(rd), .s_read_ready(rrdy[1]), .s_read_data(rdat[1]), .fill_count(cnt[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]), .underflow(un[1]), .err_clear(clr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; inputs drop again just after the edge.
  task automatic xfer(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr = w; wd = d; rd = r; clr = c;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_lvl(input string tag, input int c);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_cnt", tag, m), 64'(cnt[m]), 64'(c));
      chk($sformatf("%s_m%0d_ae", tag, m), 64'(ae[m]), 64'(c <= 1));
      chk($sformatf("%s_m%0d_af", tag, m), 64'(af[m]), 64'(c >= 3));
      chk($sformatf("%s_m%0d_wrdy", tag, m), 64'(wrdy[m]), 64'(c != 4));
      chk($sformatf("%s_m%0d_rrdy", tag, m), 64'(rrdy[m]), 64'(c != 0));
    end
  endtask

  task automatic chk_err(input string tag, input bit o, input bit u);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_ov", tag, m), 64'(ov[m]), 64'(o));
      chk($sformatf("%s_m%0d_un", tag, m), 64'(un[m]), 64'(u));
    end
  endtask

  // FWFT shows the head before the pop; standard mode shows it one edge after the pop.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_fwft"}, 64'(rdat[1]), 64'(exp));
    xfer(1'b0, 8'h00, 1'b1, 1'b0);
    chk({tag, "_std"}, 64'(rdat[0]), 64'(exp));
  endtask

  initial begin
    logic [7:0] pat;
    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_lvl("rst", 0);
    chk_err("rst", 1'b0, 1'b0);
    chk("rst_dat0", 64'(rdat[0]), 64'h0);
    chk("rst_dat1", 64'(rdat[1]), 64'h0);

    // fill / drain with threshold tracking
    for (int i = 0; i < 4; i++) begin
      pat = 8'hA0 + 8'(i);
      xfer(1'b1, pat, 1'b0, 1'b0);
      chk_lvl($sformatf("fill%0d", i), i + 1);
    end
    xfer(1'b1, 8'hEE, 1'b0, 1'b0);
    chk_lvl("fill_full", 4);
    chk_err("fill_full", 1'b1, 1'b0);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
    chk_err("clr_ov", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pat = 8'hA0 + 8'(i);
      pop_chk($sformatf("drain%0d", i), pat);
      chk_lvl($sformatf("drain%0d", i), 3 - i);
    end
    chk("empty_fwft_dat", 64'(rdat[1]), 64'h0);
    chk("empty_std_hold", 64'(rdat[0]), 64'hA3);

    // simultaneous at count 2
    xfer(1'b1, 8'hB0, 1'b0, 1'b0);
    xfer(1'b1, 8'hB1, 1'b0, 1'b0);
    chk("sim2_fwft_head", 64'(rdat[1]), 64'hB0);
    xfer(1'b1, 8'hB2, 1'b1, 1'b0);
    chk_lvl("sim2", 2);
    chk("sim2_std", 64'(rdat[0]), 64'hB0);
    pop_chk("sim2_p1", 8'hB1);
    pop_chk("sim2_p2", 8'hB2);
    chk_lvl("sim2_empty", 0);

    // empty + both: write wins, underflow set
    xfer(1'b1, 8'hC0, 1'b1, 1'b0);
    chk_lvl("sim_empty", 1);
    chk_err("sim_empty", 1'b0, 1'b1);
    chk("sim_empty_std_hold", 64'(rdat[0]), 64'hB2);
    chk("sim_empty_fwft", 64'(rdat[1]), 64'hC0);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
    chk_err("clr_un", 1'b0, 1'b0);

    // full + both: read wins, overflow set
    xfer(1'b1, 8'hC1, 1'b0, 1'b0);
    xfer(1'b1, 8'hC2, 1'b0, 1'b0);
    xfer(1'b1, 8'hC3, 1'b0, 1'b0);
    chk_lvl("sim_full_pre", 4);
    xfer(1'b1, 8'hD0, 1'b1, 1'b0);
    chk_lvl("sim_full", 3);
    chk_err("sim_full", 1'b1, 1'b0);
    chk("sim_full_std", 64'(rdat[0]), 64'hC0);
    xfer(1'b0, 8'h00, 1'b0, 1'b0);
    chk_err("ov_sticky", 1'b1, 1'b0);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
    chk_err("ov_clr", 1'b0, 1'b0);

    // error set wins over clear in the same cycle
    xfer(1'b1, 8'hD1, 1'b0, 1'b0);
    chk_lvl("err_full", 4);
    xfer(1'b1, 8'hFF, 1'b0, 1'b0);
    chk_err("err_ov", 1'b1, 1'b0);
    xfer(1'b1, 8'hFF, 1'b0, 1'b1);
    chk_err("err_ov_vs_clr", 1'b1, 1'b0);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
    chk_err("err_clr2", 1'b0, 1'b0);
    pop_chk("err_p0", 8'hC1);
    pop_chk("err_p1", 8'hC2);
    pop_chk("err_p2", 8'hC3);
    pop_chk("err_p3", 8'hD1);
    chk_lvl("err_drained", 0);

    // wrap: interleaved write/read
    for (int i = 0; i < 10; i++) begin
      pat = 8'(i);
      xfer(1'b1, pat, 1'b0, 1'b0);
      pop_chk($sformatf("wrap%0d", i), pat);
    end
    chk_lvl("wrap_end", 0);
    chk_err("wrap_end", 1'b0, 1'b0);

    // reset mid-operation with a write request pending
    xfer(1'b1, 8'hE0, 1'b0, 1'b0);
    xfer(1'b1, 8'hE1, 1'b0, 1'b0);
    xfer(1'b1, 8'hE2, 1'b0, 1'b0);
    xfer(1'b1, 8'hFF, 1'b0, 1'b0);
    xfer(1'b1, 8'hFF, 1'b0, 1'b0);
    chk_err("pre_rst", 1'b1, 1'b0);
    reset = 1'b1;
    xfer(1'b1, 8'h77, 1'b0, 1'b0);
    reset = 1'b0;
    chk_lvl("mid_rst", 0);
    chk_err("mid_rst", 1'b0, 1'b0);
    chk("mid_rst_dat0", 64'(rdat[0]), 64'h0);
    chk("mid_rst_dat1", 64'(rdat[1]), 64'h0);
    xfer(1'b1, 8'h11, 1'b0, 1'b0);
    xfer(1'b1, 8'h22, 1'b0, 1'b0);
    pop_chk("post_rst0", 8'h11);
    pop_chk("post_rst1", 8'h22);
    chk_lvl("post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
